// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) sequential arithmetic unit: mode codes,
// controller states and a table of irreducible polynomials for degrees 2..16.
package gf_pkg;

    localparam logic [1:0] MODE_MUL = 2'd0;
    localparam logic [1:0] MODE_SQR = 2'd1;
    localparam logic [1:0] MODE_POW = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ   = 2'd1,
        S_ML   = 2'd2,
        S_DONE = 2'd3
    } gf_state_t;

    localparam int unsigned GF_TBL_MIN = 2;
    localparam int unsigned GF_TBL_MAX = 16;

    // Irreducible polynomial of degree deg (bit deg set); zero outside 2..16.
    function automatic logic [16:0] gf_irred_poly(input int unsigned deg);
        logic [16:0] p;
        case (deg)
            2:       p = 17'd7;
            3:       p = 17'd11;
            4:       p = 17'd19;
            5:       p = 17'd37;
            6:       p = 17'd67;
            7:       p = 17'd137;
            8:       p = 17'd285;
            9:       p = 17'd529;
            10:      p = 17'd1033;
            11:      p = 17'd2053;
            12:      p = 17'd4179;
            13:      p = 17'd8219;
            14:      p = 17'd17475;
            15:      p = 17'd32771;
            16:      p = 17'd69643;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/gf_mul_step.sv
// One MSB-first interleaved multiply/reduce step in GF(2^m):
// acc' = ((acc << 1) mod p) ^ (y_bit ? x : 0), truncated to m bits.
module gf_mul_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         i_acc,
    input  logic [DATA_WIDTH-1:0]         i_x,
    input  logic                          i_y_bit,
    input  logic [DATA_WIDTH:0]           i_p,
    input  logic [$clog2(DATA_WIDTH):0]   i_m,
    output logic [DATA_WIDTH-1:0]         o_acc
);

    logic [DATA_WIDTH:0]   w_sh;
    logic                  w_top;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_xy;

    assign w_sh   = {i_acc, 1'b0};
    assign w_top  = w_sh[i_m];
    // A DATA_WIDTH-bit mask wraps to all ones when m equals DATA_WIDTH.
    assign w_mask = (DATA_WIDTH'(1) << i_m) - DATA_WIDTH'(1);
    assign w_xy   = i_y_bit ? i_x : '0;

    assign o_acc = DATA_WIDTH'(w_sh ^ (w_top ? i_p : '0) ^ {1'b0, w_xy}) & w_mask;

endmodule

// File: rtl/gf_modexp_seq.sv
// Sequential GF(2^m) multiply / square / exponentiate unit with runtime degree m,
// built around a single reused bit-serial interleaved multiply step.
module gf_modexp_seq
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          op_enable,
    input  logic [1:0]                    op_mode,
    input  logic [$clog2(DATA_WIDTH):0]   in_width,
    input  logic [DATA_WIDTH:0]           polyn_red_in,
    input  logic [DATA_WIDTH-1:0]         in_a,
    input  logic [DATA_WIDTH-1:0]         in_b,
    output logic                          op_busy,
    output logic                          op_finish,
    output logic                          op_error,
    output logic [DATA_WIDTH-1:0]         out_poly
);

    localparam int unsigned WW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH);

    gf_state_t             r_state;
    logic [WW-1:0]         r_m;
    logic [DATA_WIDTH:0]   r_p;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DATA_WIDTH-1:0] r_r;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [BW-1:0]         r_bit;
    logic [BW-1:0]         r_ebit;
    logic                  r_err_pend;
    logic                  r_busy;
    logic                  r_finish;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_out;

    logic [DATA_WIDTH-1:0] w_in_mask;
    logic [DATA_WIDTH-1:0] w_a_m;
    logic [DATA_WIDTH-1:0] w_b_m;
    logic                  w_p_top;
    logic                  w_in_err;
    logic                  w_last;
    logic                  w_ebit;
    logic                  w_ybit;
    logic [DATA_WIDTH-1:0] w_acc_next;

    assign w_in_mask = (DATA_WIDTH'(1) << in_width) - DATA_WIDTH'(1);
    assign w_a_m     = in_a & w_in_mask;
    assign w_b_m     = in_b & w_in_mask;
    assign w_p_top   = (in_width <= WW'(DATA_WIDTH)) ? polyn_red_in[in_width] : 1'b0;
    assign w_in_err  = (in_width < WW'(2)) || (in_width > WW'(DATA_WIDTH)) ||
                       (op_mode == MODE_RSV) || !w_p_top;

    assign w_last = (r_bit == '0);
    assign w_ebit = r_b[r_ebit];
    assign w_ybit = r_y[r_bit];

    gf_mul_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .i_acc   (r_acc),
        .i_x     (r_x),
        .i_y_bit (w_ybit),
        .i_p     (r_p),
        .i_m     (r_m),
        .o_acc   (w_acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_m        <= '0;
            r_p        <= '0;
            r_mode     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_r        <= '0;
            r_acc      <= '0;
            r_bit      <= '0;
            r_ebit     <= '0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_error    <= 1'b0;
            r_out      <= '0;
        end else begin
            r_finish <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_enable) begin
                        r_m        <= in_width;
                        r_p        <= polyn_red_in;
                        r_mode     <= op_mode;
                        r_a        <= w_a_m;
                        r_b        <= w_b_m;
                        r_acc      <= '0;
                        r_bit      <= BW'(in_width - 1'b1);
                        r_ebit     <= BW'(in_width - 1'b1);
                        r_err_pend <= w_in_err;
                        r_busy     <= 1'b1;
                        if (w_in_err) begin
                            r_state <= S_DONE;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_r     <= '0;
                        end else if (op_mode == MODE_POW) begin
                            r_state <= S_SQ;
                            r_x     <= DATA_WIDTH'(1);
                            r_y     <= DATA_WIDTH'(1);
                            r_r     <= DATA_WIDTH'(1);
                        end else begin
                            r_state <= S_ML;
                            r_x     <= w_a_m;
                            r_y     <= (op_mode == MODE_SQR) ? w_a_m : w_b_m;
                        end
                    end
                end
                S_SQ, S_ML: begin
                    r_acc <= w_acc_next;
                    r_bit <= r_bit - 1'b1;
                    // Phase transitions load the next operands directly from the
                    // finished product so the next phase starts without a bubble.
                    if (w_last) begin
                        r_acc <= '0;
                        r_bit <= BW'(r_m - 1'b1);
                        r_r   <= w_acc_next;
                        if (r_mode != MODE_POW) begin
                            r_state <= S_DONE;
                        end else if (r_state == S_SQ && w_ebit) begin
                            r_state <= S_ML;
                            r_x     <= r_a;
                            r_y     <= w_acc_next;
                        end else if (r_ebit == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SQ;
                            r_ebit  <= r_ebit - 1'b1;
                            r_x     <= w_acc_next;
                            r_y     <= w_acc_next;
                        end
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_finish <= 1'b1;
                    r_error  <= r_err_pend;
                    r_out    <= r_err_pend ? '0 : r_r;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_busy   = r_busy;
    assign op_finish = r_finish;
    assign op_error  = r_error;
    assign out_poly  = r_out;

endmodule

// File: tb/tb_gf_modexp_seq.sv
// Scoreboard bench for gf_modexp_seq: directed cases, error/robustness cases and
// a random regression against a multiply-then-reduce reference model.
module tb_gf_modexp_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_enable;
    logic [1:0]  op_mode;
    logic [5:0]  in_width;
    logic [32:0] polyn_red_in;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        op_busy;
    logic        op_finish;
    logic        op_error;
    logic [31:0] out_poly;

    typedef struct {
        logic [31:0] res;
        logic        err;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    gf_modexp_seq #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_enable    (op_enable),
        .op_mode      (op_mode),
        .in_width     (in_width),
        .polyn_red_in (polyn_red_in),
        .in_a         (in_a),
        .in_b         (in_b),
        .op_busy      (op_busy),
        .op_finish    (op_finish),
        .op_error     (op_error),
        .out_poly     (out_poly)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] tbl_poly(input int m);
        case (m)
            2: return 33'd7;       3: return 33'd11;      4: return 33'd19;
            5: return 33'd37;      6: return 33'd67;      7: return 33'd137;
            8: return 33'd285;     9: return 33'd529;     10: return 33'd1033;
            11: return 33'd2053;   12: return 33'd4179;   13: return 33'd8219;
            14: return 33'd17475;  15: return 33'd32771;  16: return 33'd69643;
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic [31:0] msk(input int m);
        logic [63:0] v;
        v = (64'd1 << m) - 64'd1;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [32:0] p, input int m);
        logic [63:0] prod;
        prod = '0;
        for (int i = 0; i < m; i++)
            if (b[i]) prod = prod ^ (64'(a) << i);
        for (int k = 2 * m - 2; k >= m; k--)
            if (prod[k]) prod = prod ^ (64'(p) << (k - m));
        return prod[31:0] & msk(m);
    endfunction

    function automatic logic [31:0] ref_pow(input logic [31:0] a, input logic [31:0] e,
                                            input logic [32:0] p, input int m);
        logic [31:0] r;
        logic [31:0] base;
        r = 32'd1;
        base = a;
        for (int i = 0; i < m; i++) begin
            if (e[i]) r = ref_mul(r, base, p, m);
            base = ref_mul(base, base, p, m);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && op_finish) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_finish", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_out"}, 64'(out_poly), 64'(e.res));
                chk({e.tag, "_err"}, 64'(op_error), 64'(e.err));
            end
        end
    end

    // Called away from a clock edge with the DUT idle; returns #1 after the edge
    // on which op_finish is seen, so a follow-up call accepts in the finish cycle.
    task automatic do_op(input string tag, input logic [1:0] mode, input int m,
                         input logic [32:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_err,
                         input int exp_lat, input bit poke);
        int lat;
        exp_t e;
        op_mode      = mode;
        in_width     = 6'(m);
        polyn_red_in = p;
        in_a         = a;
        in_b         = b;
        op_enable    = 1'b1;
        e.res = exp_res;
        e.err = exp_err;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        op_enable    = 1'b0;
        op_mode      = 2'($urandom);
        in_width     = 6'($urandom);
        polyn_red_in = {1'b0, $urandom};
        in_a         = $urandom;
        in_b         = $urandom;
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (poke && lat == 5) begin
                op_enable = 1'b1;
                op_mode   = 2'd0;
                in_width  = 6'd4;
                polyn_red_in = 33'd19;
            end else if (poke && lat == 6) begin
                op_enable = 1'b0;
            end
            if (op_finish) break;
            if (lat > 3000) begin
                chk({tag, "_timeout"}, 64'd1, 64'd0);
                break;
            end
        end
        if (exp_lat >= 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int m;
        logic [1:0]  mode;
        logic [31:0] a, b, am, bm, er;
        int lat;

        rst_n = 1'b0;
        op_enable = 1'b0;
        op_mode = '0;
        in_width = '0;
        polyn_red_in = '0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(op_busy),   64'd0);
        chk("rst_finish", 64'(op_finish), 64'd0);
        chk("rst_error",  64'(op_error),  64'd0);
        chk("rst_out",    64'(out_poly),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("mul8", 2'd0, 8, 33'h11B, 32'h57, 32'h83, 32'hC1, 1'b0, 9, 1'b0);
        @(posedge clk);
        #1;
        chk("mul8_pulse_len", 64'(op_finish), 64'd0);
        chk("mul8_idle_busy", 64'(op_busy),   64'd0);
        chk("mul8_hold",      64'(out_poly),  64'hC1);

        do_op("sqr4",  2'd1, 4,  33'd19,    32'h8,        32'h0,        32'hC,    1'b0, 5,  1'b0);
        do_op("mul16", 2'd0, 16, 33'd69643, 32'hDEAD8000, 32'hBEEF0002, 32'h100B, 1'b0, 17, 1'b0);
        do_op("pow15", 2'd2, 4,  33'd19,    32'h2,        32'hF,        32'h1,    1'b0, 33, 1'b0);
        do_op("pow0",  2'd2, 4,  33'd19,    32'h2,        32'hFFFFFFF0, 32'h1,    1'b0, 17, 1'b0);
        do_op("zmul",  2'd0, 8,  33'h11B,   32'h0,        32'h5A,       32'h0,    1'b0, 9,  1'b0);
        do_op("zpow0", 2'd2, 5,  33'd37,    32'h0,        32'h0,        32'h1,    1'b0, 26, 1'b0);
        do_op("zpow",  2'd2, 5,  33'd37,    32'h0,        32'h3,        32'h0,    1'b0, 36, 1'b0);

        do_op("err_m1",   2'd0, 1,  33'd3,   32'h1,  32'h1, 32'h0, 1'b1, 1, 1'b0);
        do_op("err_mode", 2'd3, 8,  33'h11B, 32'h57, 32'h83, 32'h0, 1'b1, 1, 1'b0);
        do_op("err_poly", 2'd0, 8,  33'h0FF, 32'h57, 32'h83, 32'h0, 1'b1, 1, 1'b0);
        do_op("err_m33",  2'd0, 33, 33'h1FFFFFFFF, 32'h1, 32'h1, 32'h0, 1'b1, 1, 1'b0);

        a = 32'h89ABCDEF;
        b = 32'h12345678;
        do_op("mul32", 2'd0, 32, 33'h1_0040_0007, a, b,
              ref_mul(a, b, 33'h1_0040_0007, 32), 1'b0, 33, 1'b0);

        do_op("pow_poke", 2'd2, 4, 33'd19, 32'h2, 32'hF, 32'h1, 1'b0, 33, 1'b1);

        op_mode = 2'd2;
        in_width = 6'd8;
        polyn_red_in = 33'h11B;
        in_a = 32'h3;
        in_b = 32'hFF;
        op_enable = 1'b1;
        @(posedge clk);
        #1;
        op_enable = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   64'(op_busy),   64'd0);
        chk("midrst_finish", 64'(op_finish), 64'd0);
        chk("midrst_out",    64'(out_poly),  64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("postrst_busy", 64'(op_busy), 64'd0);
        do_op("after_rst", 2'd0, 8, 33'h11B, 32'h57, 32'h83, 32'hC1, 1'b0, 9, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            m = int'($urandom_range(16, 2));
            mode = 2'($urandom_range(2, 0));
            if (mode == 2'd2 && m > 6) m = int'($urandom_range(6, 2));
            a = $urandom;
            b = $urandom;
            am = a & msk(m);
            bm = b & msk(m);
            case (mode)
                2'd0:    begin er = ref_mul(am, bm, tbl_poly(m), m); lat = m + 1; end
                2'd1:    begin er = ref_mul(am, am, tbl_poly(m), m); lat = m + 1; end
                default: begin
                    er = ref_pow(am, bm, tbl_poly(m), m);
                    lat = m * (m + $countones(bm)) + 1;
                end
            endcase
            do_op("rand", mode, m, tbl_poly(m), a, b, er, 1'b0, lat, 1'b0);
        end

        repeat (20) @(posedge clk);
        #1;
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
